// File: rtl/expr_string_gen.sv
// Expression character-stream generator: validates a packed digit/operator
// description and emits it as ASCII, one character per accepted beat.
module expr_string_gen #(
  parameter int MAX_TERMS = 8
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic                   start,
  input  logic [3:0]             num_terms,
  input  logic [4*MAX_TERMS-1:0] digits,
  input  logic [MAX_TERMS-2:0]   ops,
  input  logic                   out_ready,
  output logic [7:0]             out,
  output logic                   out_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DIGIT = 3'd1,
    S_OP    = 3'd2,
    S_DONE  = 3'd3,
    S_REJ   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             idx_q, idx_d;
  logic [3:0]             n_q;
  logic [4*MAX_TERMS-1:0] digits_q;
  logic [MAX_TERMS-2:0]   ops_q;
  logic                   load;
  logic                   start_ok;
  logic [3:0]             cur_dig;
  logic                   cur_op;

  // Only nibbles below num_terms are checked; unused operands are don't-care.
  always_comb begin
    start_ok = 1'b1;
    if (num_terms == 4'd0 || 32'(num_terms) > MAX_TERMS) start_ok = 1'b0;
    for (int i = 0; i < MAX_TERMS; i++) begin
      if (i < 32'(num_terms) && digits[4*i +: 4] > 4'd9) start_ok = 1'b0;
    end
  end

  always_comb begin
    cur_dig = 4'd0;
    cur_op  = 1'b0;
    for (int i = 0; i < MAX_TERMS; i++) begin
      if (idx_q == 4'(i)) cur_dig = digits_q[4*i +: 4];
    end
    for (int i = 0; i < MAX_TERMS - 1; i++) begin
      if (idx_q == 4'(i)) cur_op = ops_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (start_ok) begin
            load    = 1'b1;
            idx_d   = 4'd0;
            state_d = S_DIGIT;
          end else begin
            state_d = S_REJ;
          end
        end
      end
      S_DIGIT: begin
        if (out_ready) state_d = (idx_q == n_q - 4'd1) ? S_DONE : S_OP;
      end
      S_OP: begin
        if (out_ready) begin
          idx_d   = idx_q + 4'd1;
          state_d = S_DIGIT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_REJ:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode from registered state and index only.
  always_comb begin
    out       = 8'h00;
    out_valid = 1'b0;
    busy      = (state_q != S_IDLE);
    done      = 1'b0;
    err       = 1'b0;
    case (state_q)
      S_DIGIT: begin
        out_valid = 1'b1;
        out       = 8'h30 + {4'h0, cur_dig};
      end
      S_OP: begin
        out_valid = 1'b1;
        out       = cur_op ? 8'h2A : 8'h2B;
      end
      S_DONE:  done = 1'b1;
      S_REJ:   err  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Request payload is captured only on acceptance, so later input changes are invisible.
  always_ff @(posedge clk) begin
    if (load) begin
      n_q      <= num_terms;
      digits_q <= digits;
      ops_q    <= ops;
    end
  end

endmodule

// File: doc/expr_string_gen.md
# expr_string_gen

Character-stream generator for the digit/operator expression grammar (digit, then alternating `+`/`*` and digit). It accepts a packed expression description, validates it, and emits it as ASCII characters one per handshake beat. Every completed stream is a string the expression recognizer accepts. It sits upstream of the recognizer as the transmit end of the same 8-bit character interface.

## Interface
- `MAX_TERMS`, default 8: maximum number of digit operands per expression. Legal range is 2..15.
- `clk` input 1: rising-edge clock.
- `clr_n` input 1: synchronous active-low reset, sampled on the rising edge of `clk`.
- `start` input 1: request pulse. Sampled only in IDLE.
- `num_terms` input 4: number of digits, N. Legal range is 1..MAX_TERMS.
- `digits` input 4*MAX_TERMS: BCD operands. Nibble i is bits [4i+3:4i].
- `ops` input MAX_TERMS-1: operator i sits between digit i and digit i+1. 0 = `+` (8'h2B), 1 = `*` (8'h2A).
- `out` output 8: ASCII character. It is 8'h00 whenever `out_valid`=0.
- `out_valid` output 1: `out` holds a character.
- `out_ready` input 1: the downstream side accepts the character on the current edge.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse after the last character transfers.
- `err` output 1: one-cycle pulse when a `start` is rejected.

## Operation
- States: IDLE, DIGIT, OP, DONE, REJ. A 4-bit index register `idx` selects the current term.
- Start validation happens in IDLE with `start`=1. The request is rejected if any of these holds:
  - `num_terms`=0
  - `num_terms`>MAX_TERMS
  - any nibble i<`num_terms` of `digits` is greater than 9
- Rejected start: go to REJ and latch nothing.
- Accepted start:
  - latch `num_terms`, `digits` and `ops` into internal registers;
  - set `idx`=0;
  - go to DIGIT.
- Input changes after acceptance have no effect.
- DIGIT:
  - `out_valid`=1 and `out`=8'h30 + digit[idx].
  - On `out_ready`=1: if `idx`=N-1, go to DONE; otherwise go to OP.
- OP:
  - `out_valid`=1 and `out`=ops[idx] ? 8'h2A : 8'h2B.
  - On `out_ready`=1: `idx`<=`idx`+1 and go to DIGIT.
- DONE: `done`=1 and `out_valid`=0. Unconditionally go to IDLE next cycle.
- REJ: `err`=1 and `out_valid`=0. Unconditionally go to IDLE next cycle.
- Operator bits at index ≥ N-1 and digit nibbles at index ≥ N are ignored and never validated.
- A stream has exactly 2N-1 characters. It always begins and ends with a digit.
- `start` outside IDLE is ignored. It is not queued and does not trigger `err`.
- Handshake: while `out_valid`=1 and `out_ready`=0, `out` holds stable and the state does not advance. `out_valid` never drops until the transfer completes.
- Unknown state encodings recover to IDLE on the next edge.

## Timing
- Reset (`clr_n`=0 at an edge) forces:
  - state=IDLE and `idx`=0;
  - `out`=8'h00, `out_valid`=0, `busy`=0, `done`=0, `err`=0.
- Reset takes priority over every other input, including mid-stream. No `done` pulse is produced for an aborted stream.
- Outputs are a Moore decode of the registered state and `idx` only. There is no combinational path from `out_ready` or `start` to any output.
- Start accepted at edge T: the first character is valid in cycle T+1.
- With `out_ready` tied high:
  - one character per cycle;
  - last character in cycle T+2N-1;
  - `done` in cycle T+2N;
  - back in IDLE at T+2N+1, where a new `start` is sampled.
- A rejected start at edge T gives `err` in cycle T+1 and IDLE at T+2.
- Each cycle with `out_ready`=0 during DIGIT or OP delays all later events by exactly one cycle.

## Test plan
- Single term, `out_ready`=1: N=1, digit0=7 -> one beat `out`=8'h37, then `done` pulse the next cycle. Total 2 cycles of `busy`.
- Three terms: N=3, digits 3,4,5, ops[0]=0, ops[1]=1 -> "3+4*5" (8'h33, 2B, 34, 2A, 35) on consecutive cycles, then `done`. Feed the stream to the recognizer model and check its accept output is 1 after each digit.
- Backpressure: same stream with `out_ready` low for 2 cycles on the `+` beat -> `out`=8'h2B held 3 cycles, no characters lost or duplicated, `done` 2 cycles later than the unstalled run.
- Rejects:
  - N=0 -> `err` pulse, no `out_valid`;
  - N=MAX_TERMS+1 -> `err` pulse, no `out_valid`;
  - N=2 with digit1=4'hA -> `err` pulse, no `out_valid`;
  - N=2 with digit2=4'hF and digit1 legal -> accepted, because digit2 is unused.
- `start` pulsed mid-stream with different inputs -> ignored; the original stream completes unchanged.
- `clr_n` low on the OP beat of "1*2" -> next cycle `out_valid`=0, `busy`=0, no `done`. A fresh `start` afterwards produces the full stream from `idx`=0.
